expression_buffer: RTL and testbench
====================================

# expression_buffer

Holds the user-typed function expression as a string of 7-bit ASCII symbols and serves it to `logic` through the `symbol_iter_en` / `symbol` / `symbol_valid` pull interface, one symbol per request, terminated by NUL (0). It sits between the keyboard/editor path, which writes it, and the plotting `logic`, which reads it once per redraw.

## Interface
- `SYMBOL_WIDTH`, 7: symbol width in bits (ASCII).
- `CAPACITY`, 64: maximum stored symbols, excluding the terminator.
- `LENGTH_WIDTH`, `$clog2(CAPACITY + 1)`: derived; must not be overridden.
- `clk` in 1: clock. One clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `symbol_iter_en` in 1: a one-cycle request for the next symbol.
- `symbol` out SYMBOL_WIDTH: current symbol; meaningful only while `symbol_valid` is high.
- `symbol_valid` out 1: one-cycle strobe, one per accepted request.
- `iter_restart` in 1: rewinds the read pointer to 0 and ends the iteration.
- `append` in 1: appends `append_symbol` at the end.
- `append_symbol` in SYMBOL_WIDTH: the symbol to append.
- `backspace` in 1: removes the last symbol.
- `clear` in 1: empties the buffer.
- `edit_ready` out 1: high when edits are accepted (state IDLE).
- `full` out 1: `length == CAPACITY`.
- `length` out LENGTH_WIDTH: current stored symbol count.

## Operation
- States: IDLE (no iteration in progress) and ITER (at least one symbol emitted, terminator not yet emitted).
- Request accepted on any cycle with `symbol_iter_en` high, in either state:
  - `rd_ptr < length`: emit `mem[rd_ptr]`, `rd_ptr <= rd_ptr + 1`, state becomes ITER.
  - `rd_ptr == length`: emit 0, `rd_ptr <= 0`, state becomes IDLE (wrap-around; the next request restarts from symbol 0).
- Empty buffer: each request emits 0 immediately and the block stays in IDLE.
- `iter_restart` sets `rd_ptr <= 0` and the state to IDLE. It has priority over a same-cycle request; the request is dropped and no `symbol_valid` is produced for it.
- Edits apply only in IDLE and only when `iter_restart` and `symbol_iter_en` are both low that cycle. Otherwise they are dropped silently.
- Edit priority: `clear` > `backspace` > `append`. Only one edit applies per cycle.
  - `clear`: `length <= 0`. Memory contents are not erased.
  - `backspace`: `length <= length - 1`. Ignored when `length == 0`.
  - `append`: `mem[length] <= append_symbol`, `length <= length + 1`. Ignored when `full` is high or when `append_symbol == 0` (NUL is reserved).
- `length` never exceeds CAPACITY and never underflows.

## Timing
- Request latency is exactly 1 cycle: a request at edge N produces `symbol` and `symbol_valid` valid after edge N+1, held for one cycle.
- Back-to-back requests are supported at one symbol per cycle with no bubbles.
- `symbol` holds its last value when `symbol_valid` is low. The consumer must not sample it then.
- `edit_ready`, `full` and `length` are registered-state functions and update the cycle after the causing edit.
- An append is visible to a request issued on the following cycle.
- Reset values: `symbol` = 0, `symbol_valid` = 0, `edit_ready` = 1, `full` = 0, `length` = 0, `rd_ptr` = 0, state IDLE. Memory is not reset.
- Reset asserted mid-iteration:
  - no `symbol_valid` in the cycle after reset;
  - the buffer becomes empty;
  - a request pending in the reset cycle is dropped.

## Structure
- The shared package/header holds `SYMBOL_WIDTH` and the `SYMBOL_NUL` constant (0). `logic` uses the same definitions.
- One sub-module, `symbol_ram`, provides CAPACITY x SYMBOL_WIDTH storage with one synchronous write port and one synchronous read port. It has no reset.
- `expression_buffer` holds the FSM, `rd_ptr`, `length`, and the NUL/terminator mux. The mux is registered alongside the RAM read so that latency stays 1.

## Test plan
- Append "5", " ", "-", "1", then four single requests -> `symbol` = '5', ' ', '-', '1'. A fifth request -> 0. `edit_ready` is 0 after the first request and returns to 1 after the terminator.
- Empty buffer, `symbol_iter_en` held for 3 cycles -> three consecutive `symbol_valid` strobes, each with `symbol` = 0. The state stays IDLE.
- Append 64 'x', then append 'y' -> `full` = 1, `length` = 64, and 'y' is dropped. Streaming yields 64 'x' then 0.
- Buffer "ab": request once (gets 'a'), then pulse `iter_restart` together with a request -> no strobe. The next request -> 'a'.
- Assert `clear`, `backspace` and `append` in the same cycle on "abc" -> `length` = 0. Backspace on empty -> `length` stays 0. Append of 0 -> ignored.
- Buffer "12", request once, assert `rst` during an outstanding request -> `symbol_valid` stays 0 after reset, `length` = 0, and the next request returns 0.

Source files
------------

// File: rtl/expression_buffer_pkg.sv
// Shared definitions for the expression buffer and its consumer.
// Symbol encoding, terminator value and iteration state type.
package expression_buffer_pkg;

  localparam int SYMBOL_WIDTH = 7;

  localparam logic [SYMBOL_WIDTH-1:0] SYMBOL_NUL = '0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ITER = 1'b1
  } state_e;

endpackage

// File: rtl/expression_buffer_symbol_ram.sv
// Symbol storage: one synchronous write port, one synchronous read port.
// No reset; read data holds while the read enable is low.
module symbol_ram #(
  parameter int WIDTH  = 7,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata_q
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem[raddr];
    end
  end

endmodule

// File: rtl/expression_buffer.sv
// Stores the typed expression and serves it one symbol per request,
// followed by a NUL terminator, through a pull interface.
module expression_buffer #(
  parameter  int SYMBOL_WIDTH = expression_buffer_pkg::SYMBOL_WIDTH,
  parameter  int CAPACITY     = 64,
  localparam int LENGTH_WIDTH = $clog2(CAPACITY + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    symbol_iter_en,
  output logic [SYMBOL_WIDTH-1:0] symbol,
  output logic                    symbol_valid,
  input  logic                    iter_restart,
  input  logic                    append,
  input  logic [SYMBOL_WIDTH-1:0] append_symbol,
  input  logic                    backspace,
  input  logic                    clear,
  output logic                    edit_ready,
  output logic                    full,
  output logic [LENGTH_WIDTH-1:0] length
);

  import expression_buffer_pkg::*;

  localparam int ADDR_W = $clog2(CAPACITY);
  localparam logic [LENGTH_WIDTH-1:0] CAP_L = LENGTH_WIDTH'(CAPACITY);
  localparam logic [SYMBOL_WIDTH-1:0] NUL_W = SYMBOL_WIDTH'(SYMBOL_NUL);

  state_e state_q, state_d;
  logic [LENGTH_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LENGTH_WIDTH-1:0] length_q, length_d;
  logic valid_q, valid_d;
  logic nul_q, nul_d;

  logic ram_we;
  logic ram_re;
  logic [SYMBOL_WIDTH-1:0] ram_rdata;
  logic is_full;

  assign is_full = (length_q == CAP_L);

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    length_d = length_q;
    valid_d  = 1'b0;
    nul_d    = nul_q;
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    if (iter_restart) begin
      rd_ptr_d = '0;
      state_d  = ST_IDLE;
    end else if (symbol_iter_en) begin
      valid_d = 1'b1;
      if (rd_ptr_q < length_q) begin
        ram_re   = 1'b1;
        nul_d    = 1'b0;
        rd_ptr_d = rd_ptr_q + LENGTH_WIDTH'(1);
        state_d  = ST_ITER;
      end else begin
        nul_d    = 1'b1;
        rd_ptr_d = '0;
        state_d  = ST_IDLE;
      end
    end else if (state_q == ST_IDLE) begin
      // Edits are mutually exclusive: clear wins, then backspace
      if (clear) begin
        length_d = '0;
      end else if (backspace) begin
        if (length_q != '0) begin
          length_d = length_q - LENGTH_WIDTH'(1);
        end
      end else if (append) begin
        if (!is_full && append_symbol != NUL_W) begin
          ram_we   = 1'b1;
          length_d = length_q + LENGTH_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rd_ptr_q <= '0;
      length_q <= '0;
      valid_q  <= 1'b0;
      nul_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      length_q <= length_d;
      valid_q  <= valid_d;
      nul_q    <= nul_d;
    end
  end

  symbol_ram #(
    .WIDTH (SYMBOL_WIDTH),
    .DEPTH (CAPACITY),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk    (clk),
    .we     (ram_we),
    .waddr  (length_q[ADDR_W-1:0]),
    .wdata  (append_symbol),
    .re     (ram_re),
    .raddr  (rd_ptr_q[ADDR_W-1:0]),
    .rdata_q(ram_rdata)
  );

  // Terminator select is registered with the RAM read, keeping latency 1
  assign symbol       = nul_q ? NUL_W : ram_rdata;
  assign symbol_valid = valid_q;
  assign edit_ready   = (state_q == ST_IDLE);
  assign full         = is_full;
  assign length       = length_q;

endmodule

// File: tb/tb_expression_buffer.sv
// Directed self-checking bench for expression_buffer.
// Inputs change #1 after the rising edge; outputs are sampled there too.
module tb_expression_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic       symbol_iter_en;
  logic [6:0] symbol;
  logic       symbol_valid;
  logic       iter_restart;
  logic       append;
  logic [6:0] append_symbol;
  logic       backspace;
  logic       clear;
  logic       edit_ready;
  logic       full;
  logic [6:0] length;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  expression_buffer dut (
    .clk           (clk),
    .rst           (rst),
    .symbol_iter_en(symbol_iter_en),
    .symbol        (symbol),
    .symbol_valid  (symbol_valid),
    .iter_restart  (iter_restart),
    .append        (append),
    .append_symbol (append_symbol),
    .backspace     (backspace),
    .clear         (clear),
    .edit_ready    (edit_ready),
    .full          (full),
    .length        (length)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_append(input logic [6:0] s);
    append = 1'b1;
    append_symbol = s;
    tick();
    append = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic req(input string tag, input logic [6:0] exp);
    symbol_iter_en = 1'b1;
    tick();
    symbol_iter_en = 1'b0;
    check({tag, "_valid"}, 32'(symbol_valid), 32'd1);
    check({tag, "_sym"}, 32'(symbol), 32'(exp));
  endtask

  initial begin
    rst = 1'b1;
    symbol_iter_en = 1'b0;
    iter_restart = 1'b0;
    append = 1'b0;
    append_symbol = '0;
    backspace = 1'b0;
    clear = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_symbol", 32'(symbol), 32'd0);
    check("rst_valid", 32'(symbol_valid), 32'd0);
    check("rst_ready", 32'(edit_ready), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_length", 32'(length), 32'd0);

    // "5 -1" then four requests and a terminator
    do_append(7'h35);
    do_append(7'h20);
    do_append(7'h2d);
    do_append(7'h31);
    check("t1_length", 32'(length), 32'd4);
    req("t1_r0", 7'h35);
    check("t1_ready_iter", 32'(edit_ready), 32'd0);
    req("t1_r1", 7'h20);
    req("t1_r2", 7'h2d);
    req("t1_r3", 7'h31);
    req("t1_term", 7'h00);
    check("t1_ready_idle", 32'(edit_ready), 32'd1);
    tick();
    check("t1_valid_drop", 32'(symbol_valid), 32'd0);

    // Empty buffer, request held three cycles
    do_clear();
    check("t2_length", 32'(length), 32'd0);
    symbol_iter_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_valid", 32'(symbol_valid), 32'd1);
      check("t2_sym", 32'(symbol), 32'd0);
      check("t2_ready", 32'(edit_ready), 32'd1);
    end
    symbol_iter_en = 1'b0;

    // Fill to capacity, overflow append dropped, stream all
    for (int i = 0; i < 64; i++) do_append(7'h78);
    check("t3_full", 32'(full), 32'd1);
    check("t3_length", 32'(length), 32'd64);
    do_append(7'h79);
    check("t3_len_ovf", 32'(length), 32'd64);
    symbol_iter_en = 1'b1;
    for (int i = 0; i < 65; i++) begin
      tick();
      check("t3_valid", 32'(symbol_valid), 32'd1);
      check("t3_sym", 32'(symbol), (i < 64) ? 32'h78 : 32'h00);
    end
    symbol_iter_en = 1'b0;

    // Restart beats a same-cycle request
    do_clear();
    do_append(7'h61);
    do_append(7'h62);
    req("t4_r0", 7'h61);
    iter_restart = 1'b1;
    symbol_iter_en = 1'b1;
    tick();
    iter_restart = 1'b0;
    symbol_iter_en = 1'b0;
    check("t4_no_strobe", 32'(symbol_valid), 32'd0);
    check("t4_ready", 32'(edit_ready), 32'd1);
    req("t4_again", 7'h61);
    do_append(7'h63);
    check("t4_edit_in_iter", 32'(length), 32'd2);
    iter_restart = 1'b1;
    tick();
    iter_restart = 1'b0;

    // Edit priority and boundary edits
    do_clear();
    do_append(7'h61);
    do_append(7'h62);
    do_append(7'h63);
    check("t5_len3", 32'(length), 32'd3);
    backspace = 1'b1;
    tick();
    backspace = 1'b0;
    check("t5_bksp", 32'(length), 32'd2);
    clear = 1'b1;
    backspace = 1'b1;
    append = 1'b1;
    append_symbol = 7'h64;
    tick();
    clear = 1'b0;
    backspace = 1'b0;
    append = 1'b0;
    check("t5_prio", 32'(length), 32'd0);
    backspace = 1'b1;
    tick();
    backspace = 1'b0;
    check("t5_bksp_empty", 32'(length), 32'd0);
    do_append(7'h00);
    check("t5_nul_app", 32'(length), 32'd0);

    // Reset with a request outstanding
    do_append(7'h31);
    do_append(7'h32);
    req("t6_r0", 7'h31);
    symbol_iter_en = 1'b1;
    rst = 1'b1;
    tick();
    symbol_iter_en = 1'b0;
    rst = 1'b0;
    check("t6_valid_rst", 32'(symbol_valid), 32'd0);
    check("t6_length", 32'(length), 32'd0);
    check("t6_ready", 32'(edit_ready), 32'd1);
    tick();
    check("t6_valid_after", 32'(symbol_valid), 32'd0);
    req("t6_post", 7'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
